// File: rtl/lcb_poll_scheduler.sv
// lcb_poll_scheduler
//   Runs one polling frame over NUM_LCB local commutator blocks: for each LCB
//   it sends a request byte to the UART transmitter, forwards the returning
//   byte strobes to the byte-unpacking combiner while the response window is
//   open, enforces the response length and a per-byte timeout, and flips the
//   ping-pong buffer bank when the last LCB has been served.
//
// Ports
//   clk_i             system clock
//   reset_ni          synchronous active-low reset
//   frame_sync_i      1-cycle pulse, starts a frame
//   tx_busy_i         UART transmitter busy (level)
//   tx_start_o        1-cycle pulse, loads tx_byte_o into the transmitter
//   tx_byte_o         request byte, RQ_CODE | lcb number
//   rx_valid_i        UART byte-received strobe (level, may last >1 cycle)
//   rx_valid_gated_o  rx_valid_i forwarded to the combiner while accepted
//   lcb_number_o      LCB currently addressed
//   bank_sel_o        frame buffer bank being written, toggles per frame
//   frame_done_o      1-cycle pulse at the end of a frame
//   busy_o            high from frame start until frame_done_o
//   timeout_err_o     1-cycle pulse when an LCB response times out
//   overrun_o         1-cycle pulse, frame_sync_i seen while busy
//   err_count_o       saturating count of timeouts since reset
//   state_o           current FSM state (debug)
//
// Transmit handshake: tx_busy_i acts as an inverted ready. A request is
// handed over in exactly the cycle where the FSM is in SEND and tx_busy_i is
// low; tx_start_o is high for that single cycle and tx_byte_o is valid in it
// and held afterwards until the next hand-over.
module lcb_poll_scheduler #(
   parameter int unsigned NUM_LCB      = 24,
   parameter int unsigned BYTES_PER_RQ = 15,
   parameter logic [7:0]  RQ_CODE      = 8'hA0,
   parameter int unsigned TIMEOUT      = 4095,
   parameter int unsigned TO_W         = 16
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       frame_sync_i,
   input  logic       tx_busy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_byte_o,
   input  logic       rx_valid_i,
   output logic       rx_valid_gated_o,
   output logic [4:0] lcb_number_o,
   output logic       bank_sel_o,
   output logic       frame_done_o,
   output logic       busy_o,
   output logic       timeout_err_o,
   output logic       overrun_o,
   output logic [7:0] err_count_o,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_RECV = 2'd2,
      ST_NEXT = 2'd3
   } state_e;

   localparam int unsigned     BC_W       = $clog2(BYTES_PER_RQ + 1);
   localparam logic [BC_W-1:0] BYTES_LAST = BC_W'(BYTES_PER_RQ);
   localparam logic [4:0]      LCB_LAST   = 5'(NUM_LCB - 1);
   localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT);

   state_e          state_q, state_d;
   logic [4:0]      lcb_q, lcb_d;
   logic            bank_q, bank_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]      tx_byte_q, tx_byte_d;
   logic [7:0]      err_q, err_d;
   logic            rx_prev_q;
   logic            recv_en_q, recv_en_d;
   logic            frame_done_q, frame_done_d;
   logic            timeout_q, timeout_d;
   logic            overrun_q, overrun_d;

   logic            tx_fire;
   logic            rx_edge_acc;
   logic            timeout_hit;
   logic            last_lcb;
   logic [7:0]      req_byte;

   assign req_byte    = RQ_CODE | {3'b000, lcb_q};
   assign last_lcb    = (lcb_q == LCB_LAST);
   assign tx_fire     = (state_q == ST_SEND) && !tx_busy_i;
   // Only a rising edge of the strobe counts as a byte, and only while the
   // response window still has room.
   assign rx_edge_acc = (state_q == ST_RECV) && rx_valid_i && !rx_prev_q
                        && (byte_cnt_q < BYTES_LAST);
   // A byte arriving in the same cycle as the limit still wins.
   assign timeout_hit = (state_q == ST_RECV) && !rx_edge_acc && (to_cnt_q == TO_LIMIT);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (frame_sync_i) state_d = ST_SEND;
         ST_SEND: if (!tx_busy_i)   state_d = ST_RECV;
         ST_RECV: begin
            if (rx_edge_acc) begin
               state_d = ST_RECV;
            end else if (timeout_hit) begin
               state_d = ST_NEXT;
            end else if ((byte_cnt_q == BYTES_LAST) && !rx_valid_i) begin
               // Leave only once the last strobe has fallen, so the combiner
               // sees it for its full length.
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: state_d = last_lcb ? ST_IDLE : ST_SEND;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      tx_start_o       = tx_fire;
      tx_byte_o        = tx_fire ? req_byte : tx_byte_q;
      busy_o           = (state_q != ST_IDLE);
      rx_valid_gated_o = rx_valid_i & recv_en_q;
      state_o          = state_q;
   end

   assign lcb_number_o  = lcb_q;
   assign bank_sel_o    = bank_q;
   assign frame_done_o  = frame_done_q;
   assign timeout_err_o = timeout_q;
   assign overrun_o     = overrun_q;
   assign err_count_o   = err_q;

   // ---------------- datapath next values ----------------
   always_comb begin
      lcb_d        = lcb_q;
      bank_d       = bank_q;
      byte_cnt_d   = byte_cnt_q;
      to_cnt_d     = to_cnt_q;
      tx_byte_d    = tx_byte_q;
      err_d        = err_q;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      overrun_d    = frame_sync_i && (state_q != ST_IDLE);

      if ((state_q == ST_IDLE) && frame_sync_i) begin
         lcb_d = 5'd0;
      end

      if (state_q == ST_NEXT) begin
         if (last_lcb) begin
            bank_d       = ~bank_q;
            frame_done_d = 1'b1;
         end else begin
            lcb_d = lcb_q + 5'd1;
         end
      end

      if (tx_fire) begin
         tx_byte_d  = req_byte;
         byte_cnt_d = '0;
         to_cnt_d   = '0;
      end

      if (state_q == ST_RECV) begin
         if (rx_edge_acc) begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            to_cnt_d   = '0;
         end else if (timeout_hit) begin
            timeout_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end

      // The window stays open after the last byte only for the tail of
      // that byte's strobe; a new edge needs a fall first, which closes it.
      recv_en_d = (state_d == ST_RECV) && ((byte_cnt_d < BYTES_LAST) || rx_valid_i);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         lcb_q        <= '0;
         bank_q       <= 1'b0;
         byte_cnt_q   <= '0;
         to_cnt_q     <= '0;
         tx_byte_q    <= '0;
         err_q        <= '0;
         rx_prev_q    <= 1'b0;
         recv_en_q    <= 1'b0;
         frame_done_q <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         lcb_q        <= lcb_d;
         bank_q       <= bank_d;
         byte_cnt_q   <= byte_cnt_d;
         to_cnt_q     <= to_cnt_d;
         tx_byte_q    <= tx_byte_d;
         err_q        <= err_d;
         rx_prev_q    <= rx_valid_i;
         recv_en_q    <= recv_en_d;
         frame_done_q <= frame_done_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
      end
   end

endmodule

// File: tb/tb_lcb_poll_scheduler.sv
// Bench for lcb_poll_scheduler with NUM_LCB=3, 15 bytes per request and a
// 20-cycle timeout. A reference model advances once per clock from the
// sampled inputs and every output is compared against it mid-cycle; request
// bytes are also checked against a hand-written expected queue, and
// per-test counts are pinned with literal values.
module tb_lcb_poll_scheduler;

   localparam int         NL   = 3;
   localparam int         BPR  = 15;
   localparam int         TOUT = 20;
   localparam logic [7:0] CODE = 8'hA0;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       fs = 1'b0, txb = 1'b0, rx = 1'b0;
   logic       tx_start, gated, bank, done, busy, tout, ovr;
   logic [7:0] tx_byte, err;
   logic [4:0] lcb;
   logic [1:0] state;

   lcb_poll_scheduler #(
      .NUM_LCB(NL), .BYTES_PER_RQ(BPR), .RQ_CODE(CODE), .TIMEOUT(TOUT), .TO_W(16)
   ) dut (
      .clk_i(clk), .reset_ni(rst_n), .frame_sync_i(fs), .tx_busy_i(txb),
      .tx_start_o(tx_start), .tx_byte_o(tx_byte), .rx_valid_i(rx),
      .rx_valid_gated_o(gated), .lcb_number_o(lcb), .bank_sel_o(bank),
      .frame_done_o(done), .busy_o(busy), .timeout_err_o(tout),
      .overrun_o(ovr), .err_count_o(err), .state_o(state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // phase: 0 idle, 1 waiting to hand over request, 2 collecting response,
   // 3 one-cycle advance to next LCB / end of frame
   int         m_phase, m_lcb, m_bytes, m_quiet, m_err;
   bit         m_bank, m_prev, m_done, m_tout, m_ovr, m_edge;
   logic [7:0] m_hold;
   bit         chk_en = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = 0; m_lcb = 0; m_bytes = 0; m_quiet = 0; m_err = 0;
         m_bank = 0; m_prev = 0; m_done = 0; m_tout = 0; m_ovr = 0;
         m_hold = 8'h00;
         chk_en = 1;
      end else begin
         m_edge = rx && !m_prev;
         m_ovr  = fs && (m_phase != 0);
         m_done = 0;
         m_tout = 0;
         case (m_phase)
            0: if (fs) begin m_lcb = 0; m_phase = 1; end
            1: if (!txb) begin
                  m_hold = CODE | 8'(m_lcb);
                  m_bytes = 0; m_quiet = 0; m_phase = 2;
               end
            2: begin
               if (m_edge && m_bytes < BPR) begin
                  m_bytes++; m_quiet = 0;
               end else if (m_quiet == TOUT) begin
                  m_tout = 1;
                  m_err = (m_err < 255) ? m_err + 1 : 255;
                  m_phase = 3;
               end else if (m_bytes == BPR && !rx) begin
                  m_phase = 3;
               end else begin
                  m_quiet++;
               end
            end
            default: begin
               if (m_lcb == NL - 1) begin
                  m_bank = !m_bank; m_done = 1; m_phase = 0;
               end else begin
                  m_lcb++; m_phase = 1;
               end
            end
         endcase
         m_prev = rx;
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [7:0] exp_q[$];
   int  cyc = 0, n_tx = 0, n_rise = 0, n_done = 0, n_tout = 0, n_ovr = 0;
   int  last_rise_cyc = 0, tout_gap = 0, sync_cyc = 0, first_tx_cyc = -1;
   bit  gated_prev = 0;
   bit  exp_start, exp_gate;
   logic [7:0] exp_byte;

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         exp_start = (m_phase == 1) && !txb;
         exp_byte  = exp_start ? (CODE | 8'(m_lcb)) : m_hold;
         exp_gate  = rx && (m_phase == 2) && ((m_bytes < BPR) || m_prev);
         chk("tx_start",   32'(tx_start), 32'(exp_start));
         chk("tx_byte",    32'(tx_byte),  32'(exp_byte));
         chk("rx_gated",   32'(gated),    32'(exp_gate));
         chk("lcb_number", 32'(lcb),      32'(m_lcb));
         chk("bank_sel",   32'(bank),     32'(m_bank));
         chk("frame_done", 32'(done),     32'(m_done));
         chk("busy",       32'(busy),     32'(m_phase != 0));
         chk("timeout",    32'(tout),     32'(m_tout));
         chk("overrun",    32'(ovr),      32'(m_ovr));
         chk("err_count",  32'(err),      32'(m_err));
      end
      if (tx_start === 1'b1) begin
         n_tx++;
         if (first_tx_cyc < 0) first_tx_cyc = cyc;
         if (exp_q.size() > 0) chk("tx_byte_seq", 32'(tx_byte), 32'(exp_q.pop_front()));
         else chk("tx_unexpected", 32'(1), 32'(0));
      end
      if (gated === 1'b1 && !gated_prev) begin
         n_rise++;
         last_rise_cyc = cyc;
      end
      gated_prev = (gated === 1'b1);
      if (done === 1'b1) n_done++;
      if (tout === 1'b1) begin
         n_tout++;
         tout_gap = cyc - last_rise_cyc;
      end
      if (ovr === 1'b1) n_ovr++;
      if (fs) sync_cyc = cyc;
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_sync();
      fs = 1'b1;
      tick(1);
      fs = 1'b0;
   endtask

   // The final low phase is not waited out so the caller can catch the
   // next request promptly.
   task automatic strobes(input int n, input int hi, input int lo);
      for (int i = 0; i < n; i++) begin
         rx = 1'b1;
         tick(hi);
         rx = 1'b0;
         if (i < n - 1) tick(lo);
      end
   endtask

   task automatic wait_tx(input int bound);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (tx_start === 1'b1) seen = 1;
      end
      chk("wait_tx_start", 32'(seen), 32'(1));
      tick(1);
   endtask

   task automatic wait_done(input int bound);
      bit seen = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      chk("wait_frame_done", 32'(seen), 32'(1));
      tick(1);
   endtask

   task automatic clear_counts();
      n_tx = 0; n_rise = 0; n_done = 0; n_tout = 0; n_ovr = 0; first_tx_cyc = -1;
   endtask

   task automatic push_frame();
      for (int i = 0; i < NL; i++) exp_q.push_back(CODE | 8'(i));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      tick(3);
      @(negedge clk);
      chk("reset_busy",    32'(busy),    32'(0));
      chk("reset_err",     32'(err),     32'(0));
      chk("reset_txbyte",  32'(tx_byte), 32'(0));
      chk("reset_bank",    32'(bank),    32'(0));
      tick(1);
      rst_n = 1'b1;
      tick(2);

      // 1: nominal frame
      clear_counts();
      push_frame();
      pulse_sync();
      for (int l = 0; l < NL; l++) begin
         wait_tx(10);
         strobes(BPR, 2, 3);
      end
      wait_done(20);
      chk("t1_tx_count", 32'(n_tx), 32'(3));
      chk("t1_latency",  32'(first_tx_cyc - sync_cyc), 32'(1));
      chk("t1_gated",    32'(n_rise), 32'(45));
      chk("t1_done",     32'(n_done), 32'(1));
      chk("t1_bank",     32'(bank),   32'(1));

      // 2: LCB1 answers only 7 bytes
      clear_counts();
      push_frame();
      pulse_sync();
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(7, 2, 3);
      wait_tx(100);
      strobes(BPR, 1, 2);
      wait_done(20);
      chk("t2_timeouts", 32'(n_tout), 32'(1));
      chk("t2_gap",      32'(tout_gap), 32'(22));
      chk("t2_errcount", 32'(err),    32'(1));
      chk("t2_tx_count", 32'(n_tx),   32'(3));
      chk("t2_done",     32'(n_done), 32'(1));

      // 3: overrun mid-frame and in the final advance cycle
      clear_counts();
      push_frame();
      pulse_sync();
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_tx(10);
      pulse_sync();
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(BPR, 2, 3);
      tick(1);
      pulse_sync();
      tick(5);
      chk("t3_overrun",  32'(n_ovr),  32'(2));
      chk("t3_done",     32'(n_done), 32'(1));
      chk("t3_tx_count", 32'(n_tx),   32'(3));
      chk("t3_idle",     32'(busy),   32'(0));

      // 4: stray strobes in IDLE, then 17 strobes to LCB0
      clear_counts();
      strobes(2, 2, 3);
      tick(3);
      chk("t4_idle_blocked", 32'(n_rise), 32'(0));
      push_frame();
      pulse_sync();
      wait_tx(10);
      txb = 1'b1;
      strobes(17, 2, 3);
      tick(2);
      chk("t4_gated_lcb0", 32'(n_rise), 32'(15));
      txb = 1'b0;
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_done(20);
      chk("t4_gated_total", 32'(n_rise), 32'(45));

      // 5: transmitter busy for 50 cycles at SEND
      clear_counts();
      push_frame();
      pulse_sync();
      wait_tx(10);
      strobes(BPR, 2, 3);
      txb = 1'b1;
      tick(50);
      chk("t5_held", 32'(n_tx), 32'(1));
      txb = 1'b0;
      wait_tx(5);
      chk("t5_one_start", 32'(n_tx), 32'(2));
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_done(20);
      chk("t5_tx_count", 32'(n_tx), 32'(3));

      // 6: reset during RECV of LCB1
      clear_counts();
      exp_q.push_back(CODE);
      exp_q.push_back(CODE | 8'h01);
      pulse_sync();
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(5, 2, 3);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_busy",   32'(busy),     32'(0));
      chk("t6_lcb",    32'(lcb),      32'(0));
      chk("t6_bank",   32'(bank),     32'(0));
      chk("t6_txbyte", 32'(tx_byte),  32'(0));
      chk("t6_state",  32'(state),    32'(0));
      chk("t6_done",   32'(n_done),   32'(0));
      tick(2);
      push_frame();
      pulse_sync();
      wait_tx(10);
      chk("t6_restart_bank", 32'(bank), 32'(0));
      chk("t6_restart_lcb",  32'(lcb),  32'(0));
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_tx(10);
      strobes(BPR, 2, 3);
      wait_done(20);
      chk("t6_bank_after", 32'(bank), 32'(1));

      // 7: error counter saturation (87 silent frames -> 261 timeouts)
      clear_counts();
      for (int f = 0; f < 87; f++) begin
         push_frame();
         pulse_sync();
         wait_done(200);
      end
      chk("t7_timeouts", 32'(n_tout), 32'(261));
      chk("t7_saturate", 32'(err),    32'(255));
      chk("exp_q_empty", 32'(exp_q.size()), 32'(0));

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
